v810_hold_arb: RTL and testbench

Bus-hold arbiter that shares the V810 external memory bus (A/D/BEn/MRQn/RW/DAn/BCYSTn) between the CPU's memory access unit and NM alternate bus masters, such as DMA or video fetch.
It runs the CPU's HLDRQn/HLDAKn hold handshake and grants the bus one-hot, round-robin, to one master at a time.
It drives the OWNER select for the external bus mux in front of the data-bus resizers and RAM.
The CPU always gets the bus back between master tenures.

---
 rtl/v810_arb_pkg.sv | 16 +
 rtl/v810_hold_arb_if.sv | 41 ++++
 rtl/v810_rr_pick.sv | 40 ++++
 rtl/v810_hold_arb.sv | 144 ++++++++++++++
 tb/tb_v810_hold_arb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v810_arb_pkg.sv
// Shared types for the V810 bus-hold arbiter.
// Contents: hold_state_t, the FSM state type (its 2-bit encoding is also the
//           ST debug output), and OWNER_CPU, the OWNER value that selects the
//           CPU on the external bus mux.
package v810_arb_pkg;

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        HOLD_REQ = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } hold_state_t;

    localparam int OWNER_CPU = 0;

endpackage

// File: rtl/v810_hold_arb_if.sv
// Bus-hold handshake bundle between the arbiter, the CPU hold pins and the
// alternate bus masters.
// Ports:
//   HLDRQn      hold request to CPU, active-low        (arbiter -> CPU)
//   HLDAKn      hold acknowledge, active-low           (CPU -> arbiter)
//   CPU_DAn     CPU data-access strobe                 (CPU -> arbiter)
//   CPU_BCYSTn  CPU bus-cycle start                    (CPU -> arbiter)
//   M_REQ       per-master request level               (masters -> arbiter)
//   M_GNT       per-master grant, one-hot or zero      (arbiter -> masters)
//   M_YIELD     per-master release-now hint            (arbiter -> masters)
//   OWNER       bus mux select, 0=CPU, i+1=master i    (arbiter -> mux)
//   ST          FSM state, debug                       (arbiter -> debug)
// The master modport is the arbiter side; slave is the CPU/master/mux side.
interface v810_hold_arb_if
    import v810_arb_pkg::*;
#(
    parameter int NM = 2
);
    localparam int OW = $clog2(NM + 1);

    logic          HLDRQn;
    logic          HLDAKn;
    logic          CPU_DAn;
    logic          CPU_BCYSTn;
    logic [NM-1:0] M_REQ;
    logic [NM-1:0] M_GNT;
    logic [NM-1:0] M_YIELD;
    logic [OW-1:0] OWNER;
    hold_state_t   ST;

    modport master (
        output HLDRQn, M_GNT, M_YIELD, OWNER, ST,
        input  HLDAKn, CPU_DAn, CPU_BCYSTn, M_REQ
    );

    modport slave (
        input  HLDRQn, M_GNT, M_YIELD, OWNER, ST,
        output HLDAKn, CPU_DAn, CPU_BCYSTn, M_REQ
    );

endinterface

// File: rtl/v810_rr_pick.sv
// Combinational round-robin picker: selects the first set request bit at or
// cyclically after ptr.
// Ports:
//   req   in   NM   request vector
//   ptr   in   IW   index with highest priority this round
//   pick  out  NM   one-hot of the winner (zero when no request)
//   idx   out  IW   winner index (0 when no request)
//   any   out  1    at least one request present
module v810_rr_pick #(
    parameter int NM = 2,
    parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NM; i++) begin
            cand = IW'((int'(ptr) + i) % NM);
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/v810_hold_arb.sv
// V810 bus-hold arbiter. Shares the external memory bus between the CPU and
// NM alternate masters using the HLDRQn/HLDAKn handshake. Grants are one-hot
// and round-robin, and the CPU always owns the bus between master tenures.
// Ports:
//   CLK  in  clock; state advances on posedge CLK when CE=1
//   RES  in  synchronous active-high reset, honoured regardless of CE
//   CE   in  clock enable
//   bus  master modport of v810_hold_arb_if (hold handshake, requests,
//        grants, yield hints, OWNER mux select, ST debug state)
module v810_hold_arb
    import v810_arb_pkg::*;
#(
    parameter int NM       = 2,
    parameter int MAX_HOLD = 64,
    parameter int MIN_CPU  = 4,
    parameter int CW       = 8
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            CE,
    v810_hold_arb_if.master bus
);

    localparam int            OW        = $clog2(NM + 1);
    localparam int            IW        = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [CW-1:0] MIN_CPU_C = CW'(MIN_CPU);
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NM - 1);

    hold_state_t   state, state_nxt;
    logic          hldrqn, hldrqn_nxt;
    logic [NM-1:0] gnt, gnt_nxt;
    logic [NM-1:0] yld, yld_nxt;
    logic [OW-1:0] owner, owner_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IW-1:0] winner, winner_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic [CW-1:0] cpu_cnt, cpu_cnt_nxt;

    logic [NM-1:0] pick_vec;
    logic [IW-1:0] pick_idx;
    logic          req_any;
    logic          hold_ok;

    v810_rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .req  (bus.M_REQ),
        .ptr  (rr_ptr),
        .pick (pick_vec),
        .idx  (pick_idx),
        .any  (req_any)
    );

    // The CPU may ack while still finishing a bus cycle; only hand over once
    // both strobes show the bus idle.
    assign hold_ok = !bus.HLDAKn && bus.CPU_DAn && bus.CPU_BCYSTn;

    always_comb begin
        state_nxt    = state;
        hldrqn_nxt   = hldrqn;
        gnt_nxt      = gnt;
        yld_nxt      = yld;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        winner_nxt   = winner;
        hold_cnt_nxt = hold_cnt;
        cpu_cnt_nxt  = cpu_cnt;
        unique case (state)
            CPU_OWN: begin
                if (cpu_cnt < MIN_CPU_C) cpu_cnt_nxt = cpu_cnt + 1'b1;
                if (req_any && cpu_cnt >= MIN_CPU_C) begin
                    hldrqn_nxt = 1'b0;
                    state_nxt  = HOLD_REQ;
                end
            end
            HOLD_REQ: begin
                if (hold_ok) begin
                    if (req_any) begin
                        gnt_nxt      = pick_vec;
                        owner_nxt    = OW'(pick_idx) + OW'(1);
                        winner_nxt   = pick_idx;
                        hold_cnt_nxt = '0;
                        state_nxt    = GRANT;
                    end else begin
                        // Every request went away before the ack: give the bus
                        // back without a tenure and without rotating priority.
                        hldrqn_nxt = 1'b1;
                        state_nxt  = RELEASE;
                    end
                end
            end
            GRANT: begin
                if (hold_cnt != '1) hold_cnt_nxt = hold_cnt + 1'b1;
                if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && bus.M_REQ[winner])
                    yld_nxt[winner] = 1'b1;
                if (!bus.M_REQ[winner]) begin
                    gnt_nxt    = '0;
                    yld_nxt    = '0;
                    owner_nxt  = OW'(OWNER_CPU);
                    hldrqn_nxt = 1'b1;
                    rr_ptr_nxt = (winner == LAST_IDX) ? '0 : winner + 1'b1;
                    state_nxt  = RELEASE;
                end
            end
            RELEASE: begin
                if (bus.HLDAKn) begin
                    cpu_cnt_nxt = '0;
                    state_nxt   = CPU_OWN;
                end
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= CPU_OWN;
            hldrqn   <= 1'b1;
            gnt      <= '0;
            yld      <= '0;
            owner    <= OW'(OWNER_CPU);
            rr_ptr   <= '0;
            winner   <= '0;
            hold_cnt <= '0;
            cpu_cnt  <= MIN_CPU_C;
        end else if (CE) begin
            state    <= state_nxt;
            hldrqn   <= hldrqn_nxt;
            gnt      <= gnt_nxt;
            yld      <= yld_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            winner   <= winner_nxt;
            hold_cnt <= hold_cnt_nxt;
            cpu_cnt  <= cpu_cnt_nxt;
        end
    end

    assign bus.HLDRQn  = hldrqn;
    assign bus.M_GNT   = gnt;
    assign bus.M_YIELD = yld;
    assign bus.OWNER   = owner;
    assign bus.ST      = state;

endmodule

// File: tb/tb_v810_hold_arb.sv
// Testbench for v810_hold_arb (NM=2, MAX_HOLD=8, MIN_CPU=4). Expected grants
// are queued from a round-robin model when the ack is driven and popped when
// the grant appears.
module tb_v810_hold_arb;
    import v810_arb_pkg::*;

    localparam int NM       = 2;
    localparam int MAX_HOLD = 8;
    localparam int MIN_CPU  = 4;
    localparam int CW       = 8;

    logic CLK = 1'b0;
    logic RES;
    logic CE;
    always #5 CLK = ~CLK;

    v810_hold_arb_if #(.NM(NM)) bus ();

    v810_hold_arb #(.NM(NM), .MAX_HOLD(MAX_HOLD), .MIN_CPU(MIN_CPU), .CW(CW)) dut (
        .CLK (CLK),
        .RES (RES),
        .CE  (CE),
        .bus (bus)
    );

    int            total = 0;
    int            bad = 0;
    int            model_ptr = 0;
    logic [NM-1:0] exp_q[$];

    function automatic int exp_winner(input logic [NM-1:0] req, input int ptr);
        for (int i = 0; i < NM; i++) begin
            if (req[(ptr + i) % NM]) return (ptr + i) % NM;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RES = 1'b1;
        CE = 1'b1;
        bus.M_REQ = '0;
        bus.HLDAKn = 1'b1;
        bus.CPU_DAn = 1'b1;
        bus.CPU_BCYSTn = 1'b1;
        step();
        RES = 1'b0;
        model_ptr = 0;
        exp_q.delete();
    endtask

    // Steps until ST reaches HOLD_REQ, counting CPU_OWN samples on the way.
    task automatic wait_hold_req(output int own, output bit ok);
        own = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ST == HOLD_REQ) begin
                ok = 1'b1;
                break;
            end
            if (bus.ST == CPU_OWN) own++;
            step();
        end
    endtask

    // Ack is driven now; queue the grant the model predicts.
    task automatic push_expected();
        int w;
        w = exp_winner(bus.M_REQ, model_ptr);
        exp_q.push_back((w < 0) ? '0 : NM'(1) << w);
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        CE = 1'b0;
        RES = 1'b1;
        bus.M_REQ = 2'b11;
        bus.HLDAKn = 1'b1;
        bus.CPU_DAn = 1'b1;
        bus.CPU_BCYSTn = 1'b1;
        repeat (3) step();
        obs = {bus.HLDRQn, bus.M_GNT, bus.M_YIELD, bus.OWNER, bus.ST};
        total++;
        if (obs !== 9'b1_00_00_00_00) begin
            bad++;
            $display("FAIL reset_state: {hldrqn,gnt,yld,owner,st} got %b want %b", obs, 9'b1_00_00_00_00);
        end
        CE = 1'b1;
        RES = 1'b0;
        step();
        total++;
        if (bus.HLDRQn !== 1'b0 || bus.ST !== HOLD_REQ) begin
            bad++;
            $display("FAIL reset_first_req: hldrqn=%b st=%0d want 0/1", bus.HLDRQn, bus.ST);
        end
    endtask

    task automatic test_single();
        logic [NM-1:0] e;
        do_reset();
        bus.M_REQ = 2'b01;
        step();
        total++;
        if (bus.HLDRQn !== 1'b0 || bus.ST !== HOLD_REQ) begin
            bad++;
            $display("FAIL single_req: hldrqn=%b st=%0d want 0/1", bus.HLDRQn, bus.ST);
        end
        repeat (2) step();
        total++;
        if (bus.M_GNT !== 2'b00) begin
            bad++;
            $display("FAIL single_no_early_gnt: got %b want 00", bus.M_GNT);
        end
        bus.HLDAKn = 1'b0;
        push_expected();
        step();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.M_GNT !== e || bus.OWNER !== 2'd1 || bus.ST !== GRANT) begin
            bad++;
            $display("FAIL single_gnt: gnt=%b owner=%0d st=%0d want %b/1/2", bus.M_GNT, bus.OWNER, bus.ST, e);
        end
        repeat (3) step();
        bus.M_REQ = 2'b00;
        step();
        model_ptr = 1;
        total++;
        if (bus.M_GNT !== 2'b00 || bus.HLDRQn !== 1'b1 || bus.OWNER !== 2'd0 || bus.ST !== RELEASE) begin
            bad++;
            $display("FAIL single_drop: gnt=%b hldrqn=%b owner=%0d st=%0d want 00/1/0/3", bus.M_GNT, bus.HLDRQn, bus.OWNER, bus.ST);
        end
        step();
        total++;
        if (bus.ST !== RELEASE) begin
            bad++;
            $display("FAIL single_wait_ack_release: st=%0d want 3", bus.ST);
        end
        bus.HLDAKn = 1'b1;
        step();
        total++;
        if (bus.ST !== CPU_OWN) begin
            bad++;
            $display("FAIL single_back_to_cpu: st=%0d want 0", bus.ST);
        end
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] e;
        logic [NM-1:0] order [4];
        int own;
        bit ok;
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        bus.M_REQ = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_hold_req(own, ok);
            total++;
            if (!ok || (k > 0 && own < MIN_CPU)) begin
                bad++;
                $display("FAIL rr_cpu_own_%0d: reached=%0d cpu_own_cycles=%0d want reached=1 cycles>=%0d", k, ok, own, MIN_CPU);
            end
            bus.HLDAKn = 1'b0;
            push_expected();
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (bus.M_GNT !== e || bus.M_GNT !== order[k]) begin
                bad++;
                $display("FAIL rr_gnt_%0d: got %b want %b (order %b)", k, bus.M_GNT, e, order[k]);
            end
            repeat (9) step();
            bus.M_REQ = bus.M_REQ & ~e;
            step();
            model_ptr = (exp_winner(e, 0) + 1) % NM;
            total++;
            if (bus.M_GNT !== 2'b00 || bus.HLDRQn !== 1'b1) begin
                bad++;
                $display("FAIL rr_drop_%0d: gnt=%b hldrqn=%b want 00/1", k, bus.M_GNT, bus.HLDRQn);
            end
            bus.HLDAKn = 1'b1;
            bus.M_REQ = 2'b11;
            step();
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL rr_queue_left: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_yield();
        do_reset();
        bus.M_REQ = 2'b01;
        step();
        bus.HLDAKn = 1'b0;
        step();
        repeat (7) step();
        total++;
        if (bus.M_YIELD !== 2'b00) begin
            bad++;
            $display("FAIL yield_early: got %b want 00", bus.M_YIELD);
        end
        step();
        total++;
        if (bus.M_YIELD !== 2'b01 || bus.M_GNT !== 2'b01) begin
            bad++;
            $display("FAIL yield_set: yld=%b gnt=%b want 01/01", bus.M_YIELD, bus.M_GNT);
        end
        repeat (3) step();
        total++;
        if (bus.M_YIELD !== 2'b01 || bus.M_GNT !== 2'b01) begin
            bad++;
            $display("FAIL yield_no_revoke: yld=%b gnt=%b want 01/01", bus.M_YIELD, bus.M_GNT);
        end
        bus.M_REQ = 2'b00;
        step();
        total++;
        if (bus.M_YIELD !== 2'b00 || bus.M_GNT !== 2'b00) begin
            bad++;
            $display("FAIL yield_clear: yld=%b gnt=%b want 00/00", bus.M_YIELD, bus.M_GNT);
        end
        bus.HLDAKn = 1'b1;
        step();
    endtask

    task automatic test_busy_withdraw();
        logic [NM-1:0] e;
        int own;
        bit ok;
        do_reset();
        bus.M_REQ = 2'b10;
        step();
        bus.HLDAKn = 1'b0;
        bus.CPU_DAn = 1'b0;
        repeat (3) step();
        total++;
        if (bus.M_GNT !== 2'b00 || bus.ST !== HOLD_REQ) begin
            bad++;
            $display("FAIL busy_dan: gnt=%b st=%0d want 00/1", bus.M_GNT, bus.ST);
        end
        bus.CPU_DAn = 1'b1;
        bus.CPU_BCYSTn = 1'b0;
        step();
        total++;
        if (bus.M_GNT !== 2'b00) begin
            bad++;
            $display("FAIL busy_bcyst: gnt=%b want 00", bus.M_GNT);
        end
        bus.CPU_BCYSTn = 1'b1;
        push_expected();
        step();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.M_GNT !== e || bus.OWNER !== 2'd2) begin
            bad++;
            $display("FAIL busy_gnt: gnt=%b owner=%0d want %b/2", bus.M_GNT, bus.OWNER, e);
        end
        bus.M_REQ = 2'b00;
        step();
        model_ptr = 0;
        bus.HLDAKn = 1'b1;
        step();
        repeat (5) step();
        bus.M_REQ = 2'b11;
        step();
        bus.M_REQ = 2'b00;
        step();
        total++;
        if (bus.ST !== HOLD_REQ || bus.HLDRQn !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_keep_req: st=%0d hldrqn=%b want 1/0", bus.ST, bus.HLDRQn);
        end
        bus.HLDAKn = 1'b0;
        step();
        total++;
        if (bus.ST !== RELEASE || bus.M_GNT !== 2'b00 || bus.HLDRQn !== 1'b1) begin
            bad++;
            $display("FAIL withdraw_release: st=%0d gnt=%b hldrqn=%b want 3/00/1", bus.ST, bus.M_GNT, bus.HLDRQn);
        end
        bus.HLDAKn = 1'b1;
        step();
        bus.M_REQ = 2'b11;
        wait_hold_req(own, ok);
        bus.HLDAKn = 1'b0;
        push_expected();
        step();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (!ok || bus.M_GNT !== e) begin
            bad++;
            $display("FAIL withdraw_ptr_kept: reached=%0d gnt=%b want 1/%b", ok, bus.M_GNT, e);
        end
        bus.M_REQ = 2'b00;
        step();
        bus.HLDAKn = 1'b1;
        step();
    endtask

    task automatic test_ce_reset();
        logic [NM-1:0] e;
        logic [8:0] obs;
        do_reset();
        bus.M_REQ = 2'b01;
        step();
        bus.HLDAKn = 1'b0;
        push_expected();
        step();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.M_GNT !== e) begin
            bad++;
            $display("FAIL ce_gnt: got %b want %b", bus.M_GNT, e);
        end
        repeat (3) step();
        CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.M_REQ = (i == 2) ? 2'b00 : 2'b11;
            step();
            obs = {bus.HLDRQn, bus.M_GNT, bus.M_YIELD, bus.OWNER, bus.ST};
            total++;
            if (obs !== 9'b0_01_00_01_10) begin
                bad++;
                $display("FAIL ce_frozen_%0d: got %b want %b", i, obs, 9'b0_01_00_01_10);
            end
        end
        bus.M_REQ = 2'b01;
        CE = 1'b1;
        repeat (4) step();
        total++;
        if (bus.M_YIELD !== 2'b00) begin
            bad++;
            $display("FAIL ce_hold_cnt_frozen: yld=%b want 00", bus.M_YIELD);
        end
        step();
        total++;
        if (bus.M_YIELD !== 2'b01) begin
            bad++;
            $display("FAIL ce_hold_cnt_resume: yld=%b want 01", bus.M_YIELD);
        end
        RES = 1'b1;
        step();
        obs = {bus.HLDRQn, bus.M_GNT, bus.M_YIELD, bus.OWNER, bus.ST};
        total++;
        if (obs !== 9'b1_00_00_00_00) begin
            bad++;
            $display("FAIL mid_tenure_reset: got %b want %b", obs, 9'b1_00_00_00_00);
        end
        RES = 1'b0;
        bus.M_REQ = 2'b00;
        bus.HLDAKn = 1'b1;
        step();
    endtask

    initial begin
        RES = 1'b0;
        CE = 1'b1;
        bus.M_REQ = '0;
        bus.HLDAKn = 1'b1;
        bus.CPU_DAn = 1'b1;
        bus.CPU_BCYSTn = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_yield();
        test_busy_withdraw();
        test_ce_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
